// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO: observes the commit events of the single-cycle mips core,
// turns each register-file write or data-memory write into a trace record and
// streams the records out over a valid/ready handshake.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   clr        synchronous flush of FIFO contents, flags and drop counter
//   pc         PC of the instruction committing this cycle
//   reg_we     register write this cycle
//   reg_addr   destination register
//   reg_data   write-back data
//   mem_we     data-memory write this cycle
//   mem_addr   memory byte address
//   mem_data   store data
//   out_valid  record available (first-word-fall-through)
//   out_ready  consumer accepts the current record
//   out_type   01 = register record, 10 = memory record
//   out_pc     record PC
//   out_addr   {27'b0, reg_addr} or mem_addr
//   out_data   reg_data or mem_data
//   level      entries currently stored, 0..DEPTH
//   overflow   sticky: an event was lost because the FIFO was full
//   conflict   sticky: reg_we and mem_we were high in the same cycle
//   drop_cnt   saturating count of lost events
module commit_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [31:0]      pc,
    input  logic             reg_we,
    input  logic [4:0]       reg_addr,
    input  logic [31:0]      reg_data,
    input  logic             mem_we,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_type,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_data,
    output logic [AW:0]      level,
    output logic             overflow,
    output logic             conflict,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [AW:0]      LP_FULL    = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] LP_CNT_MAX = {CNT_W{1'b1}};

    // Record storage; contents are only meaningful below level, so no reset.
    logic [1:0]  r_mem_type [DEPTH];
    logic [31:0] r_mem_pc   [DEPTH];
    logic [31:0] r_mem_addr [DEPTH];
    logic [31:0] r_mem_data [DEPTH];

    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             r_overflow;
    logic             r_conflict;
    logic [CNT_W-1:0] r_drop_cnt;

    logic        w_reg_ev;
    logic        w_push_req;
    logic        w_pop;
    logic        w_full;
    logic        w_push;
    logic        w_ovf_drop;
    logic        w_conf_drop;
    logic        w_drop;
    logic [1:0]  w_rec_type;
    logic [31:0] w_rec_addr;
    logic [31:0] w_rec_data;

    // A write to $0 is architecturally void and never becomes an event.
    assign w_reg_ev    = reg_we && (reg_addr != 5'd0);
    assign w_push_req  = w_reg_ev || mem_we;
    assign w_pop       = out_valid && out_ready;
    assign w_full      = (r_level == LP_FULL);
    // When full, a same-cycle pop frees the slot the push needs.
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_ovf_drop  = w_push_req && w_full && !w_pop;
    // The memory event loses only when the register event actually qualifies.
    assign w_conf_drop = w_reg_ev && mem_we;
    // Both drop causes in one cycle still count as a single lost-event step.
    assign w_drop      = w_ovf_drop || w_conf_drop;

    assign w_rec_type = w_reg_ev ? 2'b01 : 2'b10;
    assign w_rec_addr = w_reg_ev ? {27'b0, reg_addr} : mem_addr;
    assign w_rec_data = w_reg_ev ? reg_data : mem_data;

    always_ff @(posedge clk) begin
        if (!clr && w_push) begin
            r_mem_type[r_wptr] <= w_rec_type;
            r_mem_pc[r_wptr]   <= pc;
            r_mem_addr[r_wptr] <= w_rec_addr;
            r_mem_data[r_wptr] <= w_rec_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_conflict <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clr) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_conflict <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_ovf_drop)       r_overflow <= 1'b1;
            if (reg_we && mem_we) r_conflict <= 1'b1;
            if (w_drop && (r_drop_cnt != LP_CNT_MAX))
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    // Output fields are gated to zero while empty, which also makes them
    // follow an asynchronous reset immediately.
    assign out_valid = (r_level != '0);
    assign out_type  = out_valid ? r_mem_type[r_rptr] : 2'b00;
    assign out_pc    = out_valid ? r_mem_pc[r_rptr]   : 32'd0;
    assign out_addr  = out_valid ? r_mem_addr[r_rptr] : 32'd0;
    assign out_data  = out_valid ? r_mem_data[r_rptr] : 32'd0;
    assign level     = r_level;
    assign overflow  = r_overflow;
    assign conflict  = r_conflict;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_commit_trace_fifo.sv
module tb_commit_trace_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             clr;
    logic [31:0]      pc;
    logic             reg_we;
    logic [4:0]       reg_addr;
    logic [31:0]      reg_data;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_data;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_type;
    logic [31:0]      out_pc;
    logic [31:0]      out_addr;
    logic [31:0]      out_data;
    logic [AW:0]      level;
    logic             overflow;
    logic             conflict;
    logic [CNT_W-1:0] drop_cnt;

    always #5 clk = ~clk;

    commit_trace_fifo #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .clr(clr), .pc(pc),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
        .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
        .level(level), .overflow(overflow), .conflict(conflict),
        .drop_cnt(drop_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a queue of records plus the sticky flags and counter.
    typedef struct {
        logic [1:0]  t;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    rec_t q[$];
    bit   m_ovf;
    bit   m_conf;
    int   m_drop;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 0;
        m_conf = 0;
        m_drop = 0;
    endtask

    // Applies the architectural rules to the inputs present before the edge.
    task automatic model_edge();
        bit   reg_ok, has_ev, popped, lost;
        int   size_before;
        rec_t r;
        if (clr) begin
            model_reset();
            return;
        end
        size_before = q.size();
        reg_ok = reg_we && (reg_addr != 0);
        has_ev = reg_ok || mem_we;
        popped = (size_before > 0) && out_ready;
        lost   = 0;
        if (reg_we && mem_we) m_conf = 1;
        if (reg_ok && mem_we) lost = 1;
        if (popped) void'(q.pop_front());
        if (has_ev) begin
            if (size_before < DEPTH || popped) begin
                if (reg_ok) begin
                    r.t = 2'b01; r.addr = {27'b0, reg_addr}; r.data = reg_data;
                end else begin
                    r.t = 2'b10; r.addr = mem_addr; r.data = mem_data;
                end
                r.pc = pc;
                q.push_back(r);
            end else begin
                m_ovf = 1;
                lost  = 1;
            end
        end
        if (lost && m_drop < (1 << CNT_W) - 1) m_drop++;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(string tag);
        bit v;
        v = (q.size() != 0);
        chk({tag, ".valid"},    32'(out_valid), 32'(v));
        chk({tag, ".level"},    32'(level),     32'(q.size()));
        chk({tag, ".overflow"}, 32'(overflow),  32'(m_ovf));
        chk({tag, ".conflict"}, 32'(conflict),  32'(m_conf));
        chk({tag, ".drop_cnt"}, 32'(drop_cnt),  32'(m_drop));
        chk({tag, ".type"},     32'(out_type),  v ? 32'(q[0].t) : 32'd0);
        chk({tag, ".pc"},       out_pc,         v ? q[0].pc   : 32'd0);
        chk({tag, ".addr"},     out_addr,       v ? q[0].addr : 32'd0);
        chk({tag, ".data"},     out_data,       v ? q[0].data : 32'd0);
    endtask

    task automatic idle();
        clr = 0; reg_we = 0; mem_we = 0;
        reg_addr = 0; reg_data = 0; mem_addr = 0; mem_data = 0; pc = 0;
    endtask

    task automatic mem_ev(logic [31:0] a, logic [31:0] d, logic [31:0] p);
        idle();
        mem_we = 1; mem_addr = a; mem_data = d; pc = p;
    endtask

    typedef struct {
        logic        reg_we;
        logic [4:0]  reg_addr;
        logic [31:0] reg_data;
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
        logic [31:0] pc;
        logic        ready;
        logic        clr;
        logic        e_valid;
        logic [1:0]  e_type;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic [4:0]  e_level;
        logic        e_conf;
        logic [15:0] e_drop;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [1:0]  h_t;
        logic [31:0] h_pc, h_a, h_d;

        vt[0] = '{1,8,32'h1234,0,0,0,32'h3000,1,0, 1,2'b01,32'h3000,32'h8,32'h1234,1,0,0};
        vt[1] = '{0,0,0,0,0,0,0,1,0,               0,2'b00,0,0,0,0,0,0};
        vt[2] = '{1,0,32'h5,0,0,0,32'h3004,1,0,    0,2'b00,0,0,0,0,0,0};
        vt[3] = '{1,3,32'h77,1,32'h100,32'h88,32'h40,0,0, 1,2'b01,32'h40,32'h3,32'h77,1,1,1};
        vt[4] = '{0,0,0,0,0,0,0,1,0,               0,2'b00,0,0,0,0,1,1};
        vt[5] = '{0,0,0,1,32'h200,32'hAB,32'h44,0,0, 1,2'b10,32'h44,32'h200,32'hAB,1,1,1};
        vt[6] = '{1,0,32'h9,1,32'h204,32'hCD,32'h48,1,0, 1,2'b10,32'h48,32'h204,32'hCD,1,1,1};
        vt[7] = '{0,0,0,0,0,0,0,0,1,               0,2'b00,0,0,0,0,0,0};

        idle();
        out_ready = 0;
        reset = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        #3 reset = 1;

        // Table-driven basic record, $0 write and conflict cases.
        for (int i = 0; i < 8; i++) begin
            reg_we = vt[i].reg_we; reg_addr = vt[i].reg_addr; reg_data = vt[i].reg_data;
            mem_we = vt[i].mem_we; mem_addr = vt[i].mem_addr; mem_data = vt[i].mem_data;
            pc = vt[i].pc; out_ready = vt[i].ready; clr = vt[i].clr;
            step();
            chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'(vt[i].e_valid));
            chk($sformatf("vec%0d.type", i),  32'(out_type),  32'(vt[i].e_type));
            chk($sformatf("vec%0d.pc", i),    out_pc,         vt[i].e_pc);
            chk($sformatf("vec%0d.addr", i),  out_addr,       vt[i].e_addr);
            chk($sformatf("vec%0d.data", i),  out_data,       vt[i].e_data);
            chk($sformatf("vec%0d.level", i), 32'(level),     32'(vt[i].e_level));
            chk($sformatf("vec%0d.conf", i),  32'(conflict),  32'(vt[i].e_conf));
            chk($sformatf("vec%0d.drop", i),  32'(drop_cnt),  32'(vt[i].e_drop));
        end
        idle();

        // Fill with 18 memory events while stalled: two are lost.
        out_ready = 0;
        for (int i = 0; i < 18; i++) begin
            mem_ev(32'(4 * i), 32'(i + 100), 32'(i));
            step();
        end
        chk("fill.level", 32'(level), 32'd16);
        chk("fill.overflow", 32'(overflow), 32'd1);
        chk("fill.drop", 32'(drop_cnt), 32'd2);

        // Push and pop together while full: level holds, nothing lost.
        chk("pp.head", out_addr, 32'h0);
        mem_ev(32'h1000, 32'hF00D, 32'h77);
        out_ready = 1;
        step();
        chk("pp.level", 32'(level), 32'd16);
        chk("pp.drop", 32'(drop_cnt), 32'd2);
        idle();

        // Drain: 0x4..0x3C in order, then the record pushed at full.
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("drain%0d.addr", i), out_addr, (i == 16) ? 32'h1000 : 32'(4 * i));
            chk($sformatf("drain%0d.valid", i), 32'(out_valid), 32'd1);
            step();
        end
        chk("drain.empty", 32'(out_valid), 32'd0);
        check_model("drain");

        // Backpressure: record held stable, then a single-cycle accept.
        out_ready = 0;
        mem_ev(32'hABC0, 32'h5555, 32'h900);
        step();
        idle();
        h_t = out_type; h_pc = out_pc; h_a = out_addr; h_d = out_data;
        chk("bp.first", out_addr, 32'hABC0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("bp%0d.type", i), 32'(out_type), 32'(h_t));
            chk($sformatf("bp%0d.pc", i),   out_pc, h_pc);
            chk($sformatf("bp%0d.addr", i), out_addr, h_a);
            chk($sformatf("bp%0d.data", i), out_data, h_d);
        end
        out_ready = 1;
        step();
        out_ready = 0;
        chk("bp.pop_level", 32'(level), 32'd0);
        step();
        chk("bp.no_dup", 32'(out_valid), 32'd0);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 3; i++) begin
            mem_ev(32'(i), 32'(i), 32'(i));
            if (i == 2) begin reg_we = 1; reg_addr = 5; end
            step();
        end
        idle();
        chk("pre_rst.level", 32'(level), 32'd3);
        #3 reset = 0;
        #1;
        model_reset();
        chk("arst.valid", 32'(out_valid), 32'd0);
        chk("arst.level", 32'(level), 32'd0);
        chk("arst.conflict", 32'(conflict), 32'd0);
        chk("arst.drop", 32'(drop_cnt), 32'd0);
        chk("arst.addr", out_addr, 32'd0);
        #2 reset = 1;

        // Clear with a concurrent event: nothing stored afterwards.
        for (int i = 0; i < 2; i++) begin
            mem_ev(32'(i + 8), 32'(i), 32'(i));
            step();
        end
        idle();
        clr = 1; reg_we = 1; reg_addr = 7; reg_data = 32'h99;
        step();
        idle();
        chk("clr.level", 32'(level), 32'd0);
        chk("clr.valid", 32'(out_valid), 32'd0);
        step();
        chk("clr.after", 32'(level), 32'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            int rdy_bias;
            rdy_bias = ((i / 200) % 3 == 0) ? 1 : 3;
            clr      = ($urandom_range(0, 99) == 0);
            reg_we   = $urandom_range(0, 1);
            reg_addr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            reg_data = $urandom;
            mem_we   = ($urandom_range(0, 2) == 0);
            mem_addr = $urandom;
            mem_data = $urandom;
            pc       = $urandom;
            out_ready = ($urandom_range(0, 3) < rdy_bias);
            step();
            check_model($sformatf("rnd%0d", i));
        end
        idle();

        // Conflicts every cycle: drop counter saturates and does not wrap.
        clr = 1;
        step();
        clr = 0;
        out_ready = 1; reg_we = 1; reg_addr = 1; mem_we = 1;
        for (int i = 0; i < 65540; i++) step();
        chk("sat.drop", 32'(drop_cnt), 32'hFFFF);
        check_model("sat");
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
